// File: rtl/mixcolumns_seq.sv
// AES-128 MixColumns, one 32-bit column per clock over four cycles with an st/done handshake.
// Defining MIXCOL_INV_EN adds an `inv` input that selects InvMixColumns; the default build is forward-only.
module mixcolumns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         st,
`ifdef MIXCOL_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    localparam int NCOL = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t       state_reg, state_next;
    logic [1:0]   col_reg, col_next;
    logic [127:0] w_reg, w_next;
    logic [127:0] out_reg, out_next;
    logic         busy_reg, busy_next;
    logic         done_reg, done_next;
`ifdef MIXCOL_INV_EN
    logic         inv_reg, inv_next;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column currently being processed, byte 0 (row 0) in the MSB.
    logic [31:0]  w_cols [NCOL];
    logic [31:0]  col_sel;
    logic [7:0]   a    [4];
    logic [7:0]   x2   [4];
    logic [7:0]   fwd  [4];
    logic [31:0]  mixed;
    logic [127:0] w_upd;

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_cols
            assign w_cols[gi] = w_reg[127-32*gi -: 32];
            // Only the active column is rewritten; the others pass through.
            assign w_upd[127-32*gi -: 32] = (col_reg == 2'(gi)) ? mixed : w_reg[127-32*gi -: 32];
        end
    endgenerate

    assign col_sel = w_cols[col_reg];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_fwd
            assign a[gi]   = col_sel[31-8*gi -: 8];
            assign x2[gi]  = xtime(a[gi]);
            // 2*a[i] ^ 3*a[i+1] ^ a[i+2] ^ a[i+3]
            assign fwd[gi] = x2[gi] ^ x2[(gi+1)%4] ^ a[(gi+1)%4] ^ a[(gi+2)%4] ^ a[(gi+3)%4];
        end
    endgenerate

`ifdef MIXCOL_INV_EN
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] invb[4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_inv
            assign x4[gi] = xtime(x2[gi]);
            assign x8[gi] = xtime(x4[gi]);
            assign m9[gi] = x8[gi] ^ a[gi];
            assign mb[gi] = x8[gi] ^ x2[gi] ^ a[gi];
            assign md[gi] = x8[gi] ^ x4[gi] ^ a[gi];
            assign me[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
            // 0e*a[i] ^ 0b*a[i+1] ^ 0d*a[i+2] ^ 09*a[i+3]
            assign invb[gi] = me[gi] ^ mb[(gi+1)%4] ^ md[(gi+2)%4] ^ m9[(gi+3)%4];
            assign mixed[31-8*gi -: 8] = inv_reg ? invb[gi] : fwd[gi];
        end
    endgenerate
`else
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            assign mixed[31-8*gi -: 8] = fwd[gi];
        end
    endgenerate
`endif

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        w_next     = w_reg;
        out_next   = out_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
`ifdef MIXCOL_INV_EN
        inv_next   = inv_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (st) begin
                    w_next     = data_in;
                    col_next   = 2'd0;
                    busy_next  = 1'b1;
                    state_next = CALC;
`ifdef MIXCOL_INV_EN
                    inv_next   = inv;
`endif
                end
            end
            CALC: begin
                w_next   = w_upd;
                col_next = col_reg + 2'd1;
                if (col_reg == 2'd3) begin
                    // Result goes straight from the update path so data_out lands on the last edge.
                    out_next   = w_upd;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            col_reg   <= 2'd0;
            w_reg     <= '0;
            out_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            w_reg     <= w_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
`ifdef MIXCOL_INV_EN
            inv_reg   <= inv_next;
`endif
        end
    end

    assign data_out = out_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
